dram_rd_checker: RTL
====================

DRAM_RD_CHECKER -- requirements
Module: dram_rd_checker

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: RAM address width; the sweep covers 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 16: RAM data width.
REQ-003 Parameter RD_LATENCY, default 0, legal 0..2: cycles from rd_addr to valid rd_data.
REQ-004 Parameter ERR_CNT_WIDTH, default 8: error counter width.
REQ-005 rd_clk  input  1: the single clock; all logic is on its rising edge.
REQ-006 rd_rst_n  input  1: asynchronous, active-low reset.
REQ-007 start  input  1: single-cycle request to begin a sweep.
REQ-008 seed  input  DATA_WIDTH: expected word at address 0; sampled when start is accepted.
REQ-009 rd_addr  output  ADDR_WIDTH: RAM read address.
REQ-010 rd_data  input  DATA_WIDTH: RAM read data.
REQ-011 busy  output  1: high from the accepted start until done.
REQ-012 done  output  1: one-cycle pulse at sweep end.
REQ-013 pass  output  1: high when the last sweep found zero errors.
REQ-014 err_cnt  output  ERR_CNT_WIDTH: mismatch count, saturating.
REQ-015 first_err_addr  output  ADDR_WIDTH: address of the first mismatch.
REQ-016 first_err_valid  output  1: first_err_addr is meaningful.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE->READ on start; this also latches seed and clears err_cnt, first_err_valid, first_err_addr and pass.
REQ-019 start SHALL be ignored in READ, DRAIN and DONE.
REQ-020 READ: rd_addr increments by one per cycle from 0 to 2**ADDR_WIDTH-1.
REQ-021 READ->DRAIN after the last address when RD_LATENCY>0; READ->DONE directly when RD_LATENCY=0.
REQ-022 DRAIN SHALL last exactly RD_LATENCY cycles, then go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Expected word for address a = seed - a, modulo 2**DATA_WIDTH (wraps below zero).
REQ-025 Each issued address SHALL carry a valid flag, the expected word and the address through a RD_LATENCY-deep pipeline.
REQ-026 The comparison SHALL use rd_data in the cycle that the delayed valid is high.
REQ-027 On mismatch: err_cnt increments, holding at all-ones once reached.
REQ-028 On the first mismatch of a sweep: first_err_addr captures the delayed address and first_err_valid is set.
REQ-029 pass SHALL be set in DONE when err_cnt==0 (including the final compare), and held until the next accepted start.
REQ-030 busy is high in READ, DRAIN and DONE.
REQ-031 With start sampled at edge k, done SHALL be high in the cycle after edge k+2**ADDR_WIDTH+RD_LATENCY.
REQ-032 rd_addr SHALL hold 0 outside READ.

Reset
REQ-033 rd_rst_n low SHALL immediately force IDLE, rd_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_valid=0, and clear the pipeline valid flags.
REQ-034 Reset mid-sweep SHALL abort the sweep without a done pulse; the next start runs a full sweep.

Structure
REQ-035 Package dram_chk_pkg SHALL hold the state enum (IDLE, READ, DRAIN, DONE) and the default width/latency constants.
REQ-036 Sub-module dram_rd_pipe SHALL implement the parameterized valid/expected/address delay line (depth RD_LATENCY, 0 = pass-through).

Verification
REQ-037 Model preloaded with 0xFFFF-a, seed=0xFFFF, RD_LATENCY=0 -> done 2049 cycles after start, pass=1, err_cnt=0, first_err_valid=0.
REQ-038 Same setup, but address 0x123 corrupted to 0x0000 -> err_cnt=1, first_err_addr=0x123, first_err_valid=1, pass=0.
REQ-039 All words wrong, ERR_CNT_WIDTH=8 -> err_cnt=255 (saturated), first_err_addr=0x000, pass=0.
REQ-040 seed=0x0005, model 0x0005-a -> address 6 expects 0xFFFF, pass=1; a second start during busy is ignored (exactly one done pulse).
REQ-041 RD_LATENCY=2 with a registered two-stage model -> pass=1, done 2051 cycles after start.
REQ-042 rd_rst_n pulsed low at address 0x400 -> all outputs reset immediately, no done pulse; a new start then completes with pass=1.

Source files
------------

// File: rtl/dram_chk_pkg.sv
// rtl/dram_chk_pkg.sv - shared state type and default sizing for the DRAM read checker
package dram_chk_pkg;

    localparam int DEF_ADDR_WIDTH    = 11;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_RD_LATENCY    = 0;
    localparam int DEF_ERR_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dram_rd_checker_if.sv
// rtl/dram_rd_checker_if.sv - RAM read port between the checker and the memory under test
interface dram_rd_checker_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/dram_rd_pipe.sv
// rtl/dram_rd_pipe.sv - delays valid/expected/address alongside the RAM read latency
module dram_rd_pipe #(
    parameter int RD_LATENCY = 0,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_exp,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    generate
        if (RD_LATENCY == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_exp   = in_exp;
            assign out_addr  = in_addr;
        end else begin : g_stages
            logic [RD_LATENCY-1:0] vld;
            logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
            logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    vld <= '0;
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        exp_q[i]  <= '0;
                        addr_q[i] <= '0;
                    end
                end else begin
                    vld[0]    <= in_valid;
                    exp_q[0]  <= in_exp;
                    addr_q[0] <= in_addr;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        vld[i]    <= vld[i-1];
                        exp_q[i]  <= exp_q[i-1];
                        addr_q[i] <= addr_q[i-1];
                    end
                end
            end

            assign out_valid = vld[RD_LATENCY-1];
            assign out_exp   = exp_q[RD_LATENCY-1];
            assign out_addr  = addr_q[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/dram_rd_checker.sv
// rtl/dram_rd_checker.sv - sweeps the whole RAM once per start and checks each word against seed - address
module dram_rd_checker
    import dram_chk_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RD_LATENCY    = DEF_RD_LATENCY,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    seed,
    dram_rd_checker_if.master        ram,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     first_err_valid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [1:0]            DRAIN_END = 2'(RD_LATENCY - 1);

    state_e                  state;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              drain_cnt;

    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_exp;
    logic [ADDR_WIDTH-1:0]   pipe_addr;
    logic                    mismatch;
    logic                    to_done;

    dram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .in_valid  (state == READ),
        .in_exp    (seed_q - DATA_WIDTH'(addr_q)),
        .in_addr   (addr_q),
        .out_valid (pipe_valid),
        .out_exp   (pipe_exp),
        .out_addr  (pipe_addr)
    );

    assign mismatch = pipe_valid && (ram.rd_data != pipe_exp);

    // The last compare lands in the same cycle as the move into DONE, so pass must fold it in.
    assign to_done  = ((state == READ) && (addr_q == LAST_ADDR) && (RD_LATENCY == 0)) ||
                      ((state == DRAIN) && (drain_cnt == DRAIN_END));

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state           <= IDLE;
            seed_q          <= '0;
            addr_q          <= '0;
            drain_cnt       <= '0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= READ;
                        seed_q          <= seed;
                        addr_q          <= '0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_addr  <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                READ: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q    <= '0;
                        drain_cnt <= '0;
                        state     <= (RD_LATENCY == 0) ? DONE : DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_END) state <= DONE;
                    else                        drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= pipe_addr;
                end
            end

            if (to_done) pass <= (err_cnt == '0) && !mismatch;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign ram.rd_addr = addr_q;

endmodule
